// File: rtl/alu_req_scheduler.sv
// Round-robin front end sharing one multi-cycle ALU between two clients.
// One op in flight; a watchdog aborts ops whose done never arrives.
module alu_req_scheduler #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*OPW-1:0]   req_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_err,
  output logic               alu_start,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_done,
  output logic               busy
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            prio;
  logic            gnt;
  logic            acc;
  logic            tmo;
  logic [TW-1:0]   timer;

  assign gnt = req_valid[prio] ? prio : ~prio;
  assign tmo = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    acc       = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          acc       = 1'b1;
          req_ready = gnt ? 2'b10 : 2'b01;
          state_nx  = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (alu_done || tmo) state_nx = RESP;
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign alu_start  = (state == ISSUE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      prio        <= 1'b0;
      timer       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (acc) begin
        prio    <= ~gnt;
        resp_id <= gnt;
        alu_a   <= gnt ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        alu_b   <= gnt ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        alu_op  <= gnt ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
      end
      if (state == ISSUE) timer <= '0;
      if (state == WAIT) begin
        timer <= timer + TW'(1);
        // done takes precedence over the watchdog on the final cycle
        if (alu_done) begin
          resp_result <= alu_result;
          resp_err    <= 1'b0;
        end else if (tmo) begin
          resp_result <= '0;
          resp_err    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Randomized bench for alu_req_scheduler against a cycle-timeline model.
// The model predicts each op's start and response cycle arithmetically.
module tb_alu_req_scheduler;
  localparam int W  = 32;
  localparam int OW = 3;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [2*OW-1:0] req_op;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_id;
  logic [W-1:0]  resp_result;
  logic          resp_err;
  logic          alu_start;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_result;
  logic          alu_done;
  logic          busy;

  always #5 clk = ~clk;

  alu_req_scheduler #(.WIDTH(W), .OPW(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_err(resp_err),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result),
    .alu_done(alu_done), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_fn(logic [31:0] a,
                                         logic [31:0] b,
                                         logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << b[4:0];
      default: return b;
    endcase
  endfunction

  function automatic int pick_dly();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12)  return int'($urandom_range(1, 8));
    if (r == 12) return TO - 1;
    if (r == 13) return TO;
    if (r == 14) return TO + 1;
    if (r == 15) return 999;
    return int'($urandom_range(20, 62));
  endfunction

  // stimulus controls
  int rv_mode = 3;
  int rr_mode = 1;
  int dly_mode = 2;
  bit fix_ops = 0;
  bit spur_en = 0;
  bit do_rst = 0;
  bit force_done = 0;

  // reference model
  int         cyc = 0;
  logic       in_op = 1'b0;
  logic       mprio = 1'b0;
  int         start_c = -10;
  int         resp_c = -10;
  int         done_c = -1;
  logic       exp_id;
  logic [31:0] exp_res;
  logic       exp_err;
  logic [31:0] ea, eb;
  logic [2:0] eop;

  // observations
  int         starts = 0;
  int         first_rv_c = 0;
  logic       rv_prev = 1'b0;
  logic [31:0] last_res;
  logic       last_err;
  logic       last_id;
  logic       act_ids[$];

  task automatic step();
    logic g;
    logic [1:0] rdy_e;
    int d;
    @(negedge clk);
    cyc++;
    rst = do_rst;
    if (do_rst) req_valid = 2'b00;
    else begin
      case (rv_mode)
        0:       req_valid = 2'($urandom_range(0, 3));
        1:       req_valid = 2'b11;
        2:       req_valid = 2'b01;
        default: req_valid = 2'b00;
      endcase
    end
    if (fix_ops) begin
      req_a  = {$urandom(), 32'hCCCCCCCC};
      req_b  = {$urandom(), 32'h33333333};
      req_op = {3'($urandom_range(0, 7)), 3'd3};
    end else begin
      req_a  = {$urandom(), $urandom()};
      req_b  = {$urandom(), $urandom()};
      req_op = 6'($urandom());
    end
    case (rr_mode)
      0:       resp_ready = ($urandom_range(0, 2) != 0);
      1:       resp_ready = 1'b1;
      default: resp_ready = 1'b0;
    endcase
    alu_done = force_done || (cyc == done_c) ||
               (spur_en && (!in_op || cyc <= start_c || cyc >= resp_c) &&
                $urandom_range(0, 5) == 0);
    alu_result = alu_done ? alu_fn(alu_a, alu_b, alu_op) : $urandom();
    #1;
    g = req_valid[mprio] ? mprio : ~mprio;
    rdy_e = (in_op || req_valid == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01);
    chk("req_ready", req_ready, rdy_e);
    chk("busy", busy, in_op);
    chk("alu_start", alu_start, in_op && cyc == start_c);
    chk("resp_valid", resp_valid, in_op && cyc >= resp_c);
    if (in_op && cyc >= start_c) begin
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_op", alu_op, eop);
    end
    if (in_op && cyc >= resp_c) begin
      chk("resp_id", resp_id, exp_id);
      chk("resp_result", resp_result, exp_res);
      chk("resp_err", resp_err, exp_err);
    end
    if (alu_start) starts++;
    if (resp_valid && !rv_prev) first_rv_c = cyc;
    rv_prev = resp_valid;
    if (resp_valid && resp_ready && !do_rst) begin
      act_ids.push_back(resp_id);
      last_res = resp_result;
      last_err = resp_err;
      last_id  = resp_id;
    end
    if (do_rst) begin
      in_op  = 1'b0;
      mprio  = 1'b0;
      done_c = -1;
    end else if (!in_op && req_valid != 2'b00) begin
      in_op   = 1'b1;
      exp_id  = g;
      mprio   = ~g;
      ea      = g ? req_a[63:32] : req_a[31:0];
      eb      = g ? req_b[63:32] : req_b[31:0];
      eop     = g ? req_op[5:3] : req_op[2:0];
      start_c = cyc + 1;
      d = (dly_mode < 0) ? pick_dly() : dly_mode;
      if (d >= 1 && d <= TO) begin
        done_c  = start_c + d;
        resp_c  = done_c + 1;
        exp_err = 1'b0;
        exp_res = alu_fn(ea, eb, eop);
      end else begin
        done_c  = -1;
        resp_c  = start_c + 1 + TO;
        exp_err = 1'b1;
        exp_res = '0;
      end
    end else if (in_op && cyc >= resp_c && resp_ready) begin
      in_op  = 1'b0;
      done_c = -1;
    end
  endtask

  task automatic drain();
    int n;
    rv_mode = 3;
    rr_mode = 1;
    n = 0;
    while (in_op && n < 300) begin
      step();
      n++;
    end
    chk("drain_bound", in_op, 1'b0);
  endtask

  task automatic run_one(int rv, int dly);
    int n;
    rv_mode  = rv;
    dly_mode = dly;
    n = 0;
    while (!in_op && n < 50) begin
      step();
      n++;
    end
    chk("accept_bound", in_op, 1'b1);
    drain();
  endtask

  initial begin
    int n;
    int s0;
    logic [31:0] r0;
    rst = 1'b1;
    req_valid = 2'b00;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    resp_ready = 1'b0;
    alu_result = '0;
    alu_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_id", resp_id, 1'b0);
    chk("rst_resp_result", resp_result, 32'h0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_alu_start", alu_start, 1'b0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", alu_op, 3'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // fairness with both requesters held valid
    act_ids.delete();
    rv_mode = 1;
    dly_mode = 2;
    rr_mode = 1;
    n = 0;
    while (act_ids.size() < 3 && n < 100) begin
      step();
      n++;
    end
    chk("fair_count", act_ids.size(), 3);
    if (act_ids.size() >= 3) begin
      chk("fair_id0", act_ids[0], 1'b0);
      chk("fair_id1", act_ids[1], 1'b1);
      chk("fair_id2", act_ids[2], 1'b0);
    end
    drain();

    // fixed operands, done 3 cycles after start
    fix_ops = 1;
    s0 = starts;
    run_one(2, 3);
    fix_ops = 0;
    chk("cc_result", last_res, 32'hFFFFFFFF);
    chk("cc_id", last_id, 1'b0);
    chk("cc_err", last_err, 1'b0);
    chk("cc_starts", starts - s0, 1);
    chk("cc_latency", first_rv_c - start_c, 4);

    // watchdog: done never arrives
    run_one(2, 999);
    chk("to_delay", first_rv_c - (start_c + 1), TO);
    chk("to_err", last_err, 1'b1);
    chk("to_result", last_res, 32'h0);

    // done exactly on the final watchdog cycle wins
    run_one(2, TO);
    chk("edge_err", last_err, 1'b0);
    chk("edge_delay", first_rv_c - (start_c + 1), TO);

    // consumer stalls for 10 cycles
    rv_mode = 2;
    dly_mode = 2;
    rr_mode = 2;
    n = 0;
    while (!(in_op && cyc + 1 >= resp_c) && n < 50) begin
      step();
      n++;
    end
    rv_mode = 1;
    step();
    chk("stall_valid", resp_valid, 1'b1);
    s0 = starts;
    r0 = resp_result;
    repeat (10) step();
    chk("stall_result", resp_result, r0);
    chk("stall_starts", starts - s0, 0);
    chk("stall_ready", req_ready, 2'b00);
    drain();

    // stray done pulses outside WAIT
    spur_en = 1;
    run_one(2, 5);
    run_one(2, 999);
    spur_en = 0;

    // reset in WAIT, then a late done
    rr_mode = 1;
    rv_mode = 2;
    dly_mode = 999;
    n = 0;
    while (!in_op && n < 20) begin
      step();
      n++;
    end
    rv_mode = 3;
    repeat (5) step();
    do_rst = 1;
    step();
    do_rst = 0;
    force_done = 1;
    step();
    force_done = 0;
    chk("wrst_busy", busy, 1'b0);
    chk("wrst_resp_valid", resp_valid, 1'b0);
    repeat (3) begin
      step();
      chk("wrst_no_resp", resp_valid, 1'b0);
    end
    rv_mode = 1;
    step();
    chk("wrst_grant", req_ready, 2'b01);
    drain();

    // random traffic
    spur_en = 1;
    rv_mode = 0;
    dly_mode = -1;
    rr_mode = 0;
    repeat (4000) step();
    spur_en = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
